// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
package uart_pkg;

  // en_16x pulses per bit period.
  localparam int OVERSAMPLE = 16;
  // Tick within the start bit at which the line is re-checked (mid-bit).
  localparam int MID_TICK   = 8;
  // Payload bits per frame.
  localparam int DATA_BITS  = 8;

  // Receiver frame states.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous single-bit input into clk.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops; the first may go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value and the chain really is two stages deep.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/receiver.sv
// UART receiver: 16x oversampled, 8 data bits, 1 stop bit, LSB first.
// Reports data available, framing error and overrun to the consumer.
module receiver
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_16x,
  input  logic       rxd,
  input  logic       clr_rda,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       ferr,
  output logic       oe
);

  localparam logic [3:0] TICK_MID  = 4'(MID_TICK - 1);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);

  logic                 rxd_s;
  logic                 rxd_prev;
  logic [1:0]           settle_cnt;
  logic                 armed;
  logic                 start_edge;
  rx_state_t            state;
  logic [3:0]           tick_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  // History flop for falling-edge detection on the synchronized line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rxd_prev <= 1'b1;
    else        rxd_prev <= rxd_s;
  end

  // After reset the synchronizer and history flops still hold their reset
  // value of 1, so a line that is already low would look like a fresh falling
  // edge. Wait until the pipeline has flushed and the real line has been seen
  // high before accepting any start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= 2'd0;
      armed      <= 1'b0;
    end else begin
      if (settle_cnt != 2'd3) settle_cnt <= settle_cnt + 2'd1;
      if (settle_cnt == 2'd3 && rxd_s) armed <= 1'b1;
    end
  end

  assign start_edge = armed & rxd_prev & ~rxd_s;

  // Frame state machine, bit assembly and consumer-facing status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      tick_cnt  <= 4'd0;
      bit_cnt   <= 4'd0;
      shift_reg <= '0;
      rx_data   <= 8'h00;
      rda       <= 1'b0;
      ferr      <= 1'b0;
      oe        <= 1'b0;
    end else begin
      // Acknowledge first; a byte completing in this same cycle assigns rda
      // again further down and that later assignment takes effect.
      if (clr_rda) begin
        rda <= 1'b0;
        oe  <= 1'b0;
      end

      case (state)
        RX_IDLE: begin
          if (start_edge) begin
            state    <= RX_START;
            tick_cnt <= 4'd0;
          end
        end

        RX_START: begin
          if (en_16x) begin
            if (tick_cnt == TICK_MID) begin
              // Still low at mid start bit: real frame, else a glitch.
              state    <= rxd_s ? RX_IDLE : RX_DATA;
              tick_cnt <= 4'd0;
              bit_cnt  <= 4'd0;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end

        RX_DATA: begin
          if (en_16x) begin
            if (tick_cnt == TICK_LAST) begin
              // LSB arrives first, so shift in from the MSB side.
              shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
              bit_cnt   <= bit_cnt + 4'd1;
              tick_cnt  <= 4'd0;
              if (bit_cnt == BIT_LAST) state <= RX_STOP;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end

        RX_STOP: begin
          if (en_16x) begin
            if (tick_cnt == TICK_LAST) begin
              rx_data  <= shift_reg;
              rda      <= 1'b1;
              ferr     <= ~rxd_s;
              // Overrun only if the previous byte was not being taken now.
              if (rda && !clr_rda) oe <= 1'b1;
              tick_cnt <= 4'd0;
              state    <= RX_IDLE;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end

        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Directed testbench for the UART receiver.
module tb_receiver;
  import uart_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en_16x;
  logic       rxd;
  logic       clr_rda;
  logic [7:0] rx_data;
  logic       rda;
  logic       ferr;
  logic       oe;

  int n_cmp = 0;
  int n_err = 0;

  receiver dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_16x  (en_16x),
    .rxd     (rxd),
    .clr_rda (clr_rda),
    .rx_data (rx_data),
    .rda     (rda),
    .ferr    (ferr),
    .oe      (oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One en_16x period: pulse high for one clk, then three quiet clks.
  // Entered and left on a falling clock edge.
  task automatic tick(input logic clr);
    en_16x  = 1'b1;
    clr_rda = clr;
    @(negedge clk);
    en_16x  = 1'b0;
    clr_rda = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) tick(1'b0);
  endtask

  task automatic pulse_clr();
    clr_rda = 1'b1;
    @(negedge clk);
    clr_rda = 1'b0;
    @(negedge clk);
  endtask

  // Drive n_ticks of a frame (start, 8 data LSB first, stop; 16 ticks each).
  // The first tick is spent by edge detection, so the stop sample lands on
  // tick 1 + 8 + 16*9 = 153.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input bit clr_done, input bit chk_lat, input int n_ticks);
    for (int t = 1; t <= n_ticks; t++) begin
      int pos;
      pos = (t - 1) / 16;
      if (pos == 0)      rxd = 1'b0;
      else if (pos <= 8) rxd = b[pos-1];
      else               rxd = stop_bit;
      if (chk_lat && t == 153) check("latency_pre", {31'd0, rda}, 32'd0);
      tick(clr_done && t == 153);
      if (chk_lat && t == 153) check("latency_post", {31'd0, rda}, 32'd1);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    rxd     = 1'b1;
    en_16x  = 1'b0;
    clr_rda = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_data", {24'd0, rx_data}, 32'h00);
    check("rst_rda", {31'd0, rda}, 32'd0);
    check("rst_ferr", {31'd0, ferr}, 32'd0);
    check("rst_oe", {31'd0, oe}, 32'd0);
    rst_n = 1'b1;
    idle(4);

    // Basic reception, acknowledge, second byte.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 160);
    check("a5_rda", {31'd0, rda}, 32'd1);
    check("a5_data", {24'd0, rx_data}, 32'hA5);
    check("a5_ferr", {31'd0, ferr}, 32'd0);
    check("a5_oe", {31'd0, oe}, 32'd0);
    pulse_clr();
    check("clr_rda", {31'd0, rda}, 32'd0);
    check("clr_oe", {31'd0, oe}, 32'd0);
    idle(2);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 160);
    check("3c_rda", {31'd0, rda}, 32'd1);
    check("3c_data", {24'd0, rx_data}, 32'h3C);
    pulse_clr();
    idle(2);

    // Short low glitch on an idle line.
    rxd = 1'b0;
    repeat (5) tick(1'b0);
    check("glitch_in_start", 32'(dut.state), 32'(RX_START));
    rxd = 1'b1;
    repeat (12) tick(1'b0);
    check("glitch_idle", 32'(dut.state), 32'(RX_IDLE));
    check("glitch_rda", {31'd0, rda}, 32'd0);

    // Framing error, line left low afterwards.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 160);
    check("55_rda", {31'd0, rda}, 32'd1);
    check("55_data", {24'd0, rx_data}, 32'h55);
    check("55_ferr", {31'd0, ferr}, 32'd1);
    repeat (40) tick(1'b0);
    check("low_line_idle", 32'(dut.state), 32'(RX_IDLE));
    pulse_clr();
    check("ferr_held", {31'd0, ferr}, 32'd1);
    check("ferr_clr_rda", {31'd0, rda}, 32'd0);
    idle(4);
    check("high_line_idle", 32'(dut.state), 32'(RX_IDLE));

    // Overrun, then acknowledge on the exact completion cycle.
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, 160);
    check("01_data", {24'd0, rx_data}, 32'h01);
    check("01_ferr", {31'd0, ferr}, 32'd0);
    check("01_oe", {31'd0, oe}, 32'd0);
    idle(2);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 160);
    check("ff_oe", {31'd0, oe}, 32'd1);
    check("ff_data", {24'd0, rx_data}, 32'hFF);
    check("ff_rda", {31'd0, rda}, 32'd1);
    idle(2);
    send_frame(8'h7E, 1'b1, 1'b1, 1'b0, 160);
    check("7e_rda", {31'd0, rda}, 32'd1);
    check("7e_oe", {31'd0, oe}, 32'd0);
    check("7e_data", {24'd0, rx_data}, 32'h7E);
    idle(2);

    // Reset in the middle of the data bits (line low at that moment).
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 88);
    check("c3_in_data", 32'(dut.state), 32'(RX_DATA));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_data", {24'd0, rx_data}, 32'h00);
    check("mid_rst_rda", {31'd0, rda}, 32'd0);
    check("mid_rst_ferr", {31'd0, ferr}, 32'd0);
    check("mid_rst_oe", {31'd0, oe}, 32'd0);
    check("mid_rst_state", 32'(dut.state), 32'(RX_IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) tick(1'b0);
    check("low_after_rst_idle", 32'(dut.state), 32'(RX_IDLE));
    check("low_after_rst_rda", {31'd0, rda}, 32'd0);
    idle(4);
    send_frame(8'h96, 1'b1, 1'b0, 1'b0, 160);
    check("96_rda", {31'd0, rda}, 32'd1);
    check("96_data", {24'd0, rx_data}, 32'h96);
    check("96_ferr", {31'd0, ferr}, 32'd0);
    check("96_oe", {31'd0, oe}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
